// File: rtl/vbs_capture.sv
// vbs_capture: receive side of the composite video link.
// Recovers line/frame timing from the 1-bit sync stream, samples the
// 128x256 active window into a 2 KB frame memory with the same layout as
// the generator, and gives the CPU a registered read/write port onto it.
//
// CPU handshake: a transfer happens on every clock where strobe is high;
// write selects the direction. Reads return data on dataOut one clock
// later and are honoured in every state. Writes only land in IDLE or DONE;
// while a capture is in progress the capture path owns the write port and
// CPU writes are dropped.
module vbs_capture #(
    parameter int X_START      = 48,
    parameter int Y_START      = 35,
    parameter int VSYNC_MIN    = 128,
    parameter int LINE_TIMEOUT = 600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sync,
    input  logic        pixel,
    input  logic        arm,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [10:0] addr,
    input  logic [7:0]  dataIn,
    input  logic        strobe,
    input  logic        write,
    output logic [7:0]  dataOut,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_VSYNC = 2'd1,
        S_CAPTURE    = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_sync_prev;
    logic [9:0]  r_line_clk;
    logic [7:0]  r_low_cnt;
    logic [8:0]  r_line_idx;
    logic [7:0]  r_shift;
    logic        r_done;
    logic        r_error;
    logic [7:0]  r_dout;
    logic [7:0]  r_mem [0:2047];

    logic        w_done_next;
    logic        w_error_next;
    logic        w_fall;
    logic        w_vsync;
    logic        w_active;
    logic [7:0]  w_y;
    logic        w_sample;
    logic        w_byte_end;
    logic [3:0]  w_k;
    logic        w_cap_we;
    logic [10:0] w_cap_addr;
    logic        w_last;
    logic        w_timeout;
    logic        w_cpu_we;
    logic        w_cpu_re;

    // Sync edge and vertical sync detection; vsync fires on the single
    // clock where the low run completes VSYNC_MIN clocks.
    assign w_fall  = ~sync & r_sync_prev;
    assign w_vsync = ~sync & (r_low_cnt == 8'(VSYNC_MIN - 1));

    // Active window decode: which line, which pixel, which byte boundary.
    assign w_active   = (r_line_idx >= 9'(Y_START)) && (r_line_idx < 9'(Y_START + 256));
    assign w_y        = 8'(r_line_idx - 9'(Y_START));
    assign w_sample   = (r_line_clk >= 10'(X_START)) && (r_line_clk < 10'(X_START + 128));
    assign w_byte_end = (r_line_clk >= 10'(X_START + 8)) && (r_line_clk <= 10'(X_START + 128)) &&
                        (((r_line_clk - 10'(X_START)) & 10'd7) == 10'd0);
    assign w_k        = 4'((r_line_clk - 10'(X_START + 8)) >> 3);

    // Odd lines repeat the previous row, so only even lines are stored.
    assign w_cap_we   = (r_state == S_CAPTURE) && w_active && ~w_y[0] && w_byte_end;
    assign w_cap_addr = {w_y[7:1], w_k};
    assign w_last     = w_cap_we && (w_y == 8'd254) && (w_k == 4'd15);
    assign w_timeout  = (r_line_clk >= 10'(LINE_TIMEOUT)) && (r_low_cnt < 8'(VSYNC_MIN));

    assign w_cpu_we = strobe & write & ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_cpu_re = strobe & ~write;

    assign busy        = (r_state == S_WAIT_VSYNC) || (r_state == S_CAPTURE);
    assign done        = r_done;
    assign error       = r_error;
    assign dataOut     = r_dout;
    assign o_dbg_state = r_state;

    // Line timing recovery: line clock, low-run counter, line index, pixel shifter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_prev <= 1'b1;
            r_line_clk  <= '0;
            r_low_cnt   <= '0;
            r_line_idx  <= '0;
            r_shift     <= '0;
        end else begin
            r_sync_prev <= sync;
            if (w_fall)
                r_line_clk <= '0;
            else if (r_line_clk != 10'd1023)
                r_line_clk <= r_line_clk + 10'd1;
            if (sync)
                r_low_cnt <= '0;
            else if (r_low_cnt != 8'd255)
                r_low_cnt <= r_low_cnt + 8'd1;
            if (w_vsync)
                r_line_idx <= '0;
            else if (w_fall && (r_line_idx != 9'd511))
                r_line_idx <= r_line_idx + 9'd1;
            // A mid-line falling edge throws away any partially assembled byte.
            if (w_fall)
                r_shift <= '0;
            else if (w_sample)
                r_shift <= {r_shift[6:0], ~pixel};
        end
    end

    // Capture FSM next state and status flag updates.
    always_comb begin
        w_state_next = r_state;
        w_done_next  = r_done;
        w_error_next = r_error;
        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_state_next = S_WAIT_VSYNC;
                    w_done_next  = 1'b0;
                    w_error_next = 1'b0;
                end
            end
            S_WAIT_VSYNC: begin
                if (w_vsync)
                    w_state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (w_timeout) begin
                    w_state_next = S_IDLE;
                    w_error_next = 1'b1;
                end else if (w_vsync) begin
                    w_state_next = S_CAPTURE;
                end else if (w_last) begin
                    w_state_next = S_DONE;
                    w_done_next  = 1'b1;
                end
            end
            S_DONE: begin
                if (arm) begin
                    w_state_next = S_WAIT_VSYNC;
                    w_done_next  = 1'b0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM state, status flags and registered CPU read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
            r_error <= w_error_next;
            if (w_cpu_re)
                r_dout <= r_mem[addr];
        end
    end

    // Frame memory write port, shared between capture and CPU.
    always_ff @(posedge clk) begin
        if (w_cap_we)
            r_mem[w_cap_addr] <= r_shift;
        else if (w_cpu_we)
            r_mem[addr] <= dataIn;
    end

endmodule

// File: doc/vbs_capture.md
Name: vbs_capture

Overview:
- Receive side of the composite video link: takes the 1-bit sync and pixel stream (4 MHz pixel clock, 256 clocks per 64 us line) and recovers frame and line timing.
- Samples the 128x256 active window into a 2 KB frame memory laid out exactly as the video generator's memory, so a captured frame read back byte-for-byte matches the source.
- The CPU accesses the memory through the same addr/dataIn/strobe/write/dataOut bus style as the generator, and arms captures through a small control handshake.

Parameters:
- X_START, 48: clocks from the detected sync falling edge to the first pixel sample of a line.
- Y_START, 35: value of the line index at which active line 0 begins.
- VSYNC_MIN, 128: consecutive low sync clocks that declare vertical sync.
- LINE_TIMEOUT, 600: clocks without a sync falling edge before lock is declared lost during capture.

Ports:
- clk  in  1  system clock, 4 MHz
- reset  in  1  asynchronous, active-high reset
- sync  in  1  composite sync, active low, synchronous to clk
- pixel  in  1  video data, 1 = white, synchronous to clk
- arm  in  1  one-clock pulse: capture the next full frame
- busy  out  1  high in WAIT_VSYNC and CAPTURE
- done  out  1  high after a complete frame has been stored
- error  out  1  high after a capture aborted on timeout
- addr  in  11  CPU byte address
- dataIn  in  8  CPU write data
- strobe  in  1  CPU access qualifier
- write  in  1  1 = write, 0 = read; valid with strobe
- dataOut  out  8  CPU read data, registered

Behaviour:
- Reset (asynchronous): state IDLE; busy, done, error = 0; dataOut = 0; all counters and the shift register = 0; syncPrev = 1. Memory contents are not reset.
- Edge detect: a falling edge is a clock where sync = 0 and syncPrev = 1.
- lineClk: cleared to 0 on a falling edge, otherwise increments, saturating at 1023.
- lowCnt: counts consecutive sync = 0 clocks and clears when sync = 1. Vsync fires once, on the clock where lowCnt reaches VSYNC_MIN-1.
- lineIdx (9 bit): cleared on vsync; incremented on each falling edge while sync is not low-held; saturates at 511.
- Active region:
  - Line is active when Y_START <= lineIdx < Y_START+256; y = lineIdx - Y_START (8 bit).
  - Pixel i (0..127) is sampled on the clock where lineClk = X_START+i.
  - The shift register shifts in ~pixel, MSB first (matching the generator, which outputs inverted memory bits).
  - After sample 8k+7, byte k is written on the next clock to address {y[7:1], k[3:0]}.
  - Only even y is written; odd lines repeat the row and are ignored.
  - A falling edge mid-line restarts lineClk and discards the partial byte.
- FSM:
  - IDLE: arm -> WAIT_VSYNC, and clears done and error.
  - WAIT_VSYNC: vsync -> CAPTURE.
  - CAPTURE, normal completion: the last byte (y = 254, k = 15) is committed -> DONE, with done = 1 on the following clock.
  - CAPTURE, timeout: lineClk >= LINE_TIMEOUT while lowCnt < VSYNC_MIN -> IDLE, error = 1, and memory keeps its partial contents.
  - CAPTURE, vsync: a vsync arriving here restarts the frame (lineIdx = 0) with no error.
  - DONE: arm -> WAIT_VSYNC, and clears done.
  - arm is ignored while busy.
- CPU port:
  - A read (strobe & ~write) returns memory[addr] on dataOut one clock later. dataOut holds its value otherwise. Reads are legal in every state.
  - CPU writes are performed only in IDLE and DONE; they are silently dropped while busy. The capture path has the only write access while busy.

Test Plan:
- Reset: assert reset mid-CAPTURE -> busy = done = error = 0 and dataOut = 0 immediately; arm afterwards -> busy = 1 the next clock.
- Loopback:
  - Preload the generator memory with addr[7:0]^addr[10:8], drive its sync/pixel into the block, pulse arm.
  - Required: done after one frame; all 2048 CPU reads match the preload.
- Vsync threshold:
  - 127-clock low pulse -> no vsync, state stays WAIT_VSYNC.
  - 128-clock low pulse -> CAPTURE entered on that clock.
- Timeout: after entering CAPTURE, hold sync high for 600 clocks -> error = 1, busy = 0, state IDLE.
- Bus arbitration:
  - CPU write 0xA5 to addr 0x010 while busy -> read returns the captured byte, not 0xA5.
  - Same write in DONE -> read returns 0xA5 with one-clock latency.
- Partial line: inject an extra sync falling edge at lineClk = X_START+20 on an active line -> bytes 0-1 written, partial byte 2 discarded, the line restarts from sample 0.
